// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_unit
// Brief    : RV32I program counter and instruction-fetch sequencer. Holds the
//            architectural PC, issues one imem request at a time, and presents
//            the returned instruction (tagged with its PC) to decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
    parameter int unsigned    N        = 32,
    parameter logic [N-1:0]   RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    output logic [N-1:0] pc_out,
    input  logic [N-1:0] pc_plus4_in,
    input  logic         redirect_in,
    input  logic [N-1:0] target_in,
    input  logic         stall_in,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [N-1:0] imem_req_addr,
    input  logic         imem_rsp_valid,
    input  logic [31:0]  imem_rsp_data,
    output logic         instr_valid_out,
    output logic [31:0]  instr_out,
    output logic [N-1:0] instr_pc_out,
    output logic         misalign_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t       r_state,       w_state_next;
    logic [N-1:0] r_pc,          w_pc_next;
    logic         r_pend_flag,   w_pend_flag_next;
    logic [N-1:0] r_pend_target, w_pend_target_next;
    logic [31:0]  r_instr,       w_instr_next;
    logic [N-1:0] r_instr_pc,    w_instr_pc_next;
    logic         r_instr_valid, w_instr_valid_next;
    logic         r_misalign,    w_misalign_next;

    // A redirect only counts when its target is word aligned; otherwise it
    // is dropped and merely flagged on misalign_out.
    logic w_redirect_ok;
    logic w_redirect_bad;
    assign w_redirect_ok  = redirect_in && (target_in[1:0] == 2'b00);
    assign w_redirect_bad = redirect_in && (target_in[1:0] != 2'b00);

    // State and datapath registers; async reset puts the unit back to IDLE
    // at RESET_PC regardless of any outstanding memory request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_pend_flag   <= 1'b0;
            r_pend_target <= '0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_misalign    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_pend_flag   <= w_pend_flag_next;
            r_pend_target <= w_pend_target_next;
            r_instr       <= w_instr_next;
            r_instr_pc    <= w_instr_pc_next;
            r_instr_valid <= w_instr_valid_next;
            r_misalign    <= w_misalign_next;
        end
    end

    // Next-state and next-datapath decode for the REQ/WAIT/HOLD fetch loop.
    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_pend_flag_next   = r_pend_flag;
        w_pend_target_next = r_pend_target;
        w_instr_next       = r_instr;
        w_instr_pc_next    = r_instr_pc;
        w_instr_valid_next = r_instr_valid;
        w_misalign_next    = w_redirect_bad;

        case (r_state)
            S_IDLE: begin
                w_state_next = S_REQ;
            end

            S_REQ: begin
                // The in-flight request still completes; a redirect here is
                // remembered so its response gets thrown away in WAIT.
                if (w_redirect_ok) begin
                    w_pend_flag_next   = 1'b1;
                    w_pend_target_next = target_in;
                end
                if (imem_req_ready) begin
                    w_state_next = S_WAIT;
                end
            end

            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (r_pend_flag || w_redirect_ok) begin
                        // Stale fetch: drop the data and restart at the target,
                        // a same-cycle redirect beating the remembered one.
                        w_pc_next        = w_redirect_ok ? target_in : r_pend_target;
                        w_pend_flag_next = 1'b0;
                        w_state_next     = S_REQ;
                    end else begin
                        w_instr_next       = imem_rsp_data;
                        w_instr_pc_next    = r_pc;
                        w_instr_valid_next = 1'b1;
                        w_pc_next          = pc_plus4_in;
                        w_state_next       = S_HOLD;
                    end
                end else if (w_redirect_ok) begin
                    w_pend_flag_next   = 1'b1;
                    w_pend_target_next = target_in;
                end
            end

            S_HOLD: begin
                // Redirect wins over stall; the held instruction is squashed.
                if (w_redirect_ok) begin
                    w_instr_valid_next = 1'b0;
                    w_pc_next          = target_in;
                    w_state_next       = S_REQ;
                end else if (!stall_in) begin
                    w_instr_valid_next = 1'b0;
                    w_state_next       = S_REQ;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign pc_out          = r_pc;
    assign imem_req_valid  = (r_state == S_REQ);
    assign imem_req_addr   = r_pc;
    assign instr_valid_out = r_instr_valid;
    assign instr_out       = r_instr;
    assign instr_pc_out    = r_instr_pc;
    assign misalign_out    = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_unit
// Brief    : Self-checking bench for fetch_pc_unit: directed scenarios then
//            random traffic, compared every cycle against a transaction model
//            of the fetch flow and a latency-programmable memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

    logic clk;
    logic rst;

    // Main instance (RESET_PC = 0x100)
    logic [31:0] pc_out, pc_plus4_in, target_in, imem_req_addr, imem_rsp_data;
    logic [31:0] instr_out, instr_pc_out;
    logic        redirect_in, stall_in, imem_req_valid, imem_req_ready;
    logic        imem_rsp_valid, instr_valid_out, misalign_out;

    // Wrap instance (RESET_PC = 0xFFFF_FFFC)
    logic [31:0] pc_out_w, pc_plus4_w, req_addr_w, instr_w, instr_pc_w;
    logic        req_valid_w, ready_w, rsp_valid_w, instr_valid_w, misalign_w;

    int checks = 0;
    int errors = 0;

    // Transaction model of the fetch flow
    bit          m_idle, m_req, m_wait, m_hold, m_pend, m_mis;
    logic [31:0] m_pc, m_ptgt, m_instr, m_ipc;

    // Memory model: one outstanding request, response mem_delay cycles late
    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_delay;
    int          mem_lat;

    logic [31:0] wq[$];
    bit          acc_w;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External PC+4 adders
    assign pc_plus4_in = pc_out + 32'd4;
    assign pc_plus4_w  = pc_out_w + 32'd4;

    fetch_pc_unit #(.N(32), .RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst(rst), .pc_out(pc_out), .pc_plus4_in(pc_plus4_in),
        .redirect_in(redirect_in), .target_in(target_in), .stall_in(stall_in),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_valid_out(instr_valid_out),
        .instr_out(instr_out), .instr_pc_out(instr_pc_out),
        .misalign_out(misalign_out)
    );

    fetch_pc_unit #(.N(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .pc_out(pc_out_w), .pc_plus4_in(pc_plus4_w),
        .redirect_in(1'b0), .target_in(32'h0), .stall_in(1'b0),
        .imem_req_valid(req_valid_w), .imem_req_ready(ready_w),
        .imem_req_addr(req_addr_w), .imem_rsp_valid(rsp_valid_w),
        .imem_rsp_data(32'h0000_0013), .instr_valid_out(instr_valid_w),
        .instr_out(instr_w), .instr_pc_out(instr_pc_w),
        .misalign_out(misalign_w)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_idle = 1'b1; m_req = 1'b0; m_wait = 1'b0; m_hold = 1'b0;
        m_pend = 1'b0; m_mis = 1'b0;
        m_pc = 32'h0000_0100; m_ptgt = '0; m_instr = '0; m_ipc = '0;
    endtask

    task automatic check_outputs();
        chk("pc_out", pc_out, m_pc);
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, m_req});
        if (m_req) chk("req_addr", imem_req_addr, m_pc);
        chk("instr_valid", {31'b0, instr_valid_out}, {31'b0, m_hold});
        if (m_hold) begin
            chk("instr", instr_out, m_instr);
            chk("instr_pc", instr_pc_out, m_ipc);
        end
        chk("misalign", {31'b0, misalign_out}, {31'b0, m_mis});
    endtask

    // One clock cycle: check, drive inputs at the falling edge, advance models.
    task automatic tick(input bit rdy, input bit redir, input logic [31:0] tgt, input bit stl);
        bit          rsp_now;
        bit          ok;
        logic [31:0] rdata;
        @(negedge clk);
        check_outputs();
        rsp_now = mem_busy && (mem_delay == 0);
        rdata   = rsp_now ? memf(mem_addr) : $urandom();
        imem_req_ready = rdy;
        redirect_in    = redir;
        target_in      = tgt;
        stall_in       = stl;
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rdata;

        if (rsp_now) mem_busy = 1'b0;
        else if (mem_busy) mem_delay--;
        if (m_req && rdy) begin
            mem_busy = 1'b1; mem_addr = m_pc; mem_delay = mem_lat;
        end

        ok    = redir && (tgt[1:0] == 2'b00);
        m_mis = redir && (tgt[1:0] != 2'b00);
        if (m_idle) begin
            m_idle = 1'b0; m_req = 1'b1;
        end else if (m_req) begin
            if (ok) begin m_pend = 1'b1; m_ptgt = tgt; end
            if (rdy) begin m_req = 1'b0; m_wait = 1'b1; end
        end else if (m_wait) begin
            if (rsp_now) begin
                m_wait = 1'b0;
                if (m_pend || ok) begin
                    m_pc = ok ? tgt : m_ptgt; m_pend = 1'b0; m_req = 1'b1;
                end else begin
                    m_instr = rdata; m_ipc = m_pc; m_pc = m_pc + 32'd4; m_hold = 1'b1;
                end
            end else if (ok) begin
                m_pend = 1'b1; m_ptgt = tgt;
            end
        end else if (m_hold) begin
            if (ok) begin
                m_hold = 1'b0; m_pc = tgt; m_req = 1'b1;
            end else if (!stl) begin
                m_hold = 1'b0; m_req = 1'b1;
            end
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_pc", pc_out, 32'h0000_0100);
        chk("rst_instr_valid", {31'b0, instr_valid_out}, 32'h0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("rst_misalign", {31'b0, misalign_out}, 32'h0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [31:0] t;
        rst = 1'b1;
        redirect_in = 1'b0; target_in = '0; stall_in = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        ready_w = 1'b0; rsp_valid_w = 1'b0; acc_w = 1'b0;
        mem_busy = 1'b0; mem_addr = '0; mem_delay = 0; mem_lat = 0;
        model_reset();

        // Reset state of both instances
        #1;
        chk("init_pc", pc_out, 32'h0000_0100);
        chk("init_pc_wrap", pc_out_w, 32'hFFFF_FFFC);
        chk("init_instr", instr_out, 32'h0);
        chk("init_instr_pc", instr_pc_out, 32'h0);
        chk("init_req_valid", {31'b0, imem_req_valid}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Wrap: 0xFFFF_FFFC advances to 0x0000_0000
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (req_valid_w) wq.push_back(req_addr_w);
            ready_w     = 1'b1;
            rsp_valid_w = acc_w;
            acc_w       = req_valid_w;
        end
        chk("wrap_req_count", {31'b0, wq.size() >= 2}, 32'h1);
        if (wq.size() >= 2) begin
            chk("wrap_req0", wq[0], 32'hFFFF_FFFC);
            chk("wrap_req1", wq[1], 32'h0000_0000);
        end

        // Sequential fetch from 0x100
        do_reset();
        mem_lat = 0;
        repeat (9) tick(1'b1, 1'b0, 32'h0, 1'b0);
        #6;
        chk("seq_pc_end", pc_out, 32'h0000_010C);
        chk("seq_last_pc", instr_pc_out, 32'h0000_0108);
        chk("seq_valid", {31'b0, instr_valid_out}, 32'h1);

        // Stall in HOLD for 5 cycles, then release
        repeat (5) tick(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (3) tick(1'b1, 1'b0, 32'h0, 1'b0);

        // Redirect with stall in HOLD
        tick(1'b1, 1'b1, 32'h0000_0200, 1'b1);
        repeat (3) tick(1'b1, 1'b0, 32'h0, 1'b0);

        // Redirect while WAIT, response three cycles after acceptance
        mem_lat = 2;
        tick(1'b1, 1'b0, 32'h0, 1'b0);
        tick(1'b1, 1'b1, 32'h0000_0080, 1'b0);
        repeat (4) tick(1'b1, 1'b0, 32'h0, 1'b0);

        // Misaligned redirect
        mem_lat = 0;
        repeat (2) tick(1'b1, 1'b0, 32'h0, 1'b0);
        tick(1'b1, 1'b1, 32'h0000_0202, 1'b0);
        repeat (4) tick(1'b1, 1'b0, 32'h0, 1'b0);

        // Reset mid-WAIT; the late response must be ignored
        mem_lat = 2;
        for (int i = 0; i < 10 && !m_wait; i++) tick(1'b1, 1'b0, 32'h0, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        do_reset();
        repeat (4) tick(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (4) tick(1'b1, 1'b0, 32'h0, 1'b0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            t = $urandom();
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            mem_lat = $urandom_range(0, 2);
            tick($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, t,
                 $urandom_range(0, 9) < 4);
        end
        tick(1'b0, 1'b0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
